scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of the dwell count input.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  begin scanning; sampled only in IDLE.
REQ-005 SHALL have port stop  input  1  abort scanning; sampled in every state.
REQ-006 SHALL have port single  input  1  1 = one frame then IDLE, 0 = continuous; latched when start is accepted.
REQ-007 SHALL have port dwell  input  DWELL_W  cycles each position is held; sampled on each entry to DWELL.
REQ-008 SHALL have port mask  input  8  bit k = 1 enables position k; sampled whenever the next position is computed.
REQ-009 SHALL have port sel  output  3  current position code, driving a 3-to-8 decoder select input.
REQ-010 SHALL have port sel_valid  output  1  sel is to be decoded and applied.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, DWELL and ADVANCE; all outputs SHALL be registered.
REQ-014 In IDLE, start=1, stop=0 and mask!=0 SHALL load sel with the lowest set mask bit, latch single, load the dwell counter and enter DWELL on the next edge.
REQ-015 In IDLE, start with mask==0 SHALL be ignored: the block stays in IDLE with no output change.
REQ-016 In DWELL, sel_valid SHALL be 1 and sel SHALL be held for max(dwell,1) consecutive cycles; dwell=0 SHALL behave as dwell=1.
REQ-017 On the last DWELL cycle, the next position SHALL be the lowest set mask bit strictly above sel, and the block SHALL enter ADVANCE with sel updated to it.
REQ-018 If the last DWELL cycle finds no set mask bit above sel, it is end of frame: frame_done SHALL be 1 for exactly the following cycle.
REQ-019 At end of frame with latched single=1, the block SHALL enter IDLE; with single=0, it SHALL enter ADVANCE with sel set to the lowest set mask bit (wrap-around).
REQ-020 If mask==0 when the next position is computed, the block SHALL enter IDLE without pulsing frame_done.
REQ-021 ADVANCE SHALL last exactly one cycle with sel_valid=0 (blanking gap), then enter DWELL with the dwell counter reloaded.
REQ-022 stop=1 SHALL force IDLE on the next edge from any state, with sel_valid=0, frame_done=0 and busy=0; stop SHALL win over start and over end of frame.
REQ-023 sel SHALL hold its last value in IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 sel_valid SHALL never be 1 for a position whose mask bit was 0 at the time that position was computed.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, sel=0, sel_valid=0, frame_done=0, busy=0 and clear the dwell counter and latched single, regardless of clk.
REQ-027 Reset asserted mid-DWELL or mid-ADVANCE SHALL abort the scan with no frame_done pulse.
REQ-028 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-029 mask=FF, dwell=2, single=1, start -> sel_valid pattern 2 on / 1 off for sel=0..7; frame_done on the cycle after sel=7 ends; IDLE; busy high 23 cycles.
REQ-030 mask=8'b1000_0101, dwell=1, single=0 -> sel 0,2,7,0,2,7,... with a 1-cycle gap each step and frame_done once per wrap, continuing until stop.
REQ-031 dwell=0 and mask=01, single=0 -> sel=0 valid 1 cycle, gap 1 cycle, repeating; frame_done every 2 cycles.
REQ-032 stop asserted in the 2nd cycle of a dwell=5 position, and separately stop with start in IDLE -> next cycle sel_valid=0, busy=0, no frame_done.
REQ-033 start with mask=0 -> busy stays 0; mask cleared to 0 mid-run -> IDLE at the next step with no frame_done.
REQ-034 rst_n pulsed low between clock edges mid-DWELL -> outputs zero immediately; a fresh start then begins at the lowest set mask bit.

Source files
------------

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-bit decoder select through the enabled mask
// positions, holding each for a programmable dwell with a one-cycle blanking gap.
//   in : clk, rst_n (async, active-low), start, stop, single, dwell, mask
//   out: sel, sel_valid, frame_done, busy (all registered)
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               frame_done,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        ADVANCE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic               single_q, single_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // {found, index} of the lowest set bit
    function automatic logic [3:0] lowest(input logic [7:0] m);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [7:0]         above_m;
    logic [3:0]         first_pos;
    logic [3:0]         next_pos;
    logic [DWELL_W-1:0] dwell_load;

    // Bits strictly above sel; 2<<7 overflows to 0 so nothing remains above 7.
    assign above_m    = mask & ~(8'(8'd2 << sel_q) - 8'd1);
    assign first_pos  = lowest(mask);
    assign next_pos   = lowest(above_m);
    // A zero dwell is held for one cycle like dwell=1.
    assign dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        single_d     = single_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && first_pos[3]) begin
                    state_d     = DWELL;
                    sel_d       = first_pos[2:0];
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    single_d    = single;
                    cnt_d       = dwell_load;
                end
            end
            DWELL: begin
                sel_valid_d = 1'b1;
                busy_d      = 1'b1;
                if (cnt_q > DWELL_W'(1)) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    sel_valid_d = 1'b0;
                    if (mask == 8'h00) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else if (next_pos[3]) begin
                        state_d = ADVANCE;
                        sel_d   = next_pos[2:0];
                    end else begin
                        frame_done_d = 1'b1;
                        if (single_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ADVANCE;
                            sel_d   = first_pos[2:0];
                        end
                    end
                end
            end
            ADVANCE: begin
                state_d     = DWELL;
                sel_valid_d = 1'b1;
                busy_d      = 1'b1;
                cnt_d       = dwell_load;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // stop beats start and end of frame; sel keeps its last value
        if (stop) begin
            state_d      = IDLE;
            sel_d        = sel_q;
            sel_valid_d  = 1'b0;
            frame_done_d = 1'b0;
            busy_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 3'd0;
            sel_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            single_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            single_q     <= single_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed and randomized checks of scan_sequencer
// against a per-cycle expected trace built from the position list.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       single = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] mask = 8'd0;
    logic [2:0] sel;
    logic       sel_valid;
    logic       frame_done;
    logic       busy;

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .single     (single),
        .dwell      (dwell),
        .mask       (mask),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       v;
        logic       fd;
        logic       b;
    } exp_t;

    exp_t tr[$];
    int   n_tests = 0;
    int   n_fail = 0;
    logic [2:0] cur_sel = 3'd0;

    function automatic exp_t mk(input int s, input bit v, input bit fd, input bit b);
        exp_t x;
        x.sel = 3'(s);
        x.v   = v;
        x.fd  = fd;
        x.b   = b;
        return x;
    endfunction

    // Expected outputs for cycles after the start edge, for a run with
    // constant mask/dwell and no stop.
    function automatic void build(input logic [7:0] m, input logic [7:0] dw,
                                  input bit s, input int n);
        int pos[$];
        int d;
        bit done;
        done = 1'b0;
        tr.delete();
        for (int i = 0; i < 8; i++) if (m[i]) pos.push_back(i);
        d = (dw == 8'd0) ? 1 : int'(dw);
        while (!done && tr.size() < n) begin
            for (int i = 0; i < pos.size() && !done; i++) begin
                for (int j = 0; j < d; j++) tr.push_back(mk(pos[i], 1, 0, 1));
                if (i < pos.size() - 1) tr.push_back(mk(pos[i+1], 0, 0, 1));
                else if (s) begin
                    tr.push_back(mk(pos[i], 0, 1, 0));
                    done = 1'b1;
                end else tr.push_back(mk(pos[0], 0, 1, 1));
            end
        end
        while (tr.size() < n) tr.push_back(mk(int'(tr[$].sel), 0, 0, 0));
    endfunction

    function automatic exp_t obs();
        return {sel, sel_valid, frame_done, busy};
    endfunction

    task automatic check(input string tag, input exp_t o, input exp_t e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    exp_t e;
    int   busy_cnt, fd_cnt, sa, n;
    bit   stopped;
    logic [7:0] m, dw;
    bit   sg;

    initial begin
        // reset state
        #1;
        check("reset", obs(), mk(0, 0, 0, 0));
        #13 rst_n = 1'b1;
        step();
        check("post_reset_idle", obs(), mk(0, 0, 0, 0));

        // full mask, dwell 2, single frame
        mask = 8'hFF; dwell = 8'd2; single = 1'b1;
        build(8'hFF, 8'd2, 1'b1, 30);
        start = 1'b1;
        step();
        start = 1'b0;
        busy_cnt = 0; fd_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) step();
            check($sformatf("ff_d2_c%0d", k), obs(), tr[k]);
            busy_cnt += int'(busy);
            fd_cnt += int'(frame_done);
        end
        n_tests++;
        assert (busy_cnt == 23 && fd_cnt == 1) else begin
            n_fail++;
            $error("FAIL ff_busy_len: observed busy=%0d fd=%0d expected busy=23 fd=1",
                   busy_cnt, fd_cnt);
        end
        cur_sel = 3'd7;

        // start with empty mask is ignored
        mask = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        check("mask0_start", obs(), mk(int'(cur_sel), 0, 0, 0));

        // stop together with start in IDLE
        mask = 8'hFF; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("stop_start_idle", obs(), mk(int'(cur_sel), 0, 0, 0));

        // stop in the 2nd cycle of a dwell=5 position
        mask = 8'h10; dwell = 8'd5; single = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("d5_c0", obs(), mk(4, 1, 0, 1));
        step();
        check("d5_c1", obs(), mk(4, 1, 0, 1));
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("d5_stop", obs(), mk(4, 0, 0, 0));
        cur_sel = 3'd4;

        // mask cleared mid-run: IDLE at next step without frame_done
        mask = 8'h0C; dwell = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        check("mclr_c0", obs(), mk(2, 1, 0, 1));
        step();
        check("mclr_c1", obs(), mk(2, 1, 0, 1));
        mask = 8'h00;
        step();
        check("mclr_c2", obs(), mk(2, 1, 0, 1));
        step();
        check("mclr_idle", obs(), mk(2, 0, 0, 0));
        step();
        check("mclr_nofd", obs(), mk(2, 0, 0, 0));

        // asynchronous reset mid-DWELL
        mask = 8'h60; dwell = 8'd4; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("rst_pre", obs(), mk(5, 1, 0, 1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", obs(), mk(0, 0, 0, 0));
        #3 rst_n = 1'b1;
        step();
        check("rst_idle", obs(), mk(0, 0, 0, 0));
        mask = 8'h60; dwell = 8'd1; start = 1'b1;
        build(8'h60, 8'd1, 1'b0, 6);
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            check($sformatf("rst_restart_c%0d", k), obs(), tr[k]);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        cur_sel = tr[5].sel;
        check("rst_restart_stop", obs(), mk(int'(cur_sel), 0, 0, 0));

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            m  = 8'($urandom_range(1, 255));
            dw = 8'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            n  = 48;
            sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : 0;
            build(m, dw, sg, n);
            mask = m; dwell = dw; single = sg; start = 1'b1;
            step();
            start = 1'b0;
            single = 1'($urandom);
            check($sformatf("rnd%0d_c0", r), obs(), tr[0]);
            cur_sel = tr[0].sel;
            stopped = 1'b0;
            for (int k = 1; k < n && !stopped; k++) begin
                start = 1'b0;
                if (k == sa) stop = 1'b1;
                else if (tr[k-1].b) start = 1'($urandom_range(0, 1));
                step();
                if (k == sa) begin
                    e = mk(int'(tr[k-1].sel), 0, 0, 0);
                    stopped = 1'b1;
                    stop = 1'b0;
                end else e = tr[k];
                check($sformatf("rnd%0d_c%0d", r, k), obs(), e);
                cur_sel = e.sel;
            end
            start = 1'b0;
            if (!stopped) begin
                stop = 1'b1;
                step();
                stop = 1'b0;
                check($sformatf("rnd%0d_stop", r), obs(), mk(int'(cur_sel), 0, 0, 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
